// File: rtl/echo_delay_sched.sv
// Round-robin pulse-width echo scheduler: the winning requester's high time is
// measured on a shared counter, then replayed as a delay ending in a done pulse.
module echo_delay_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            clr,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic            sat
);

  localparam int LW = $clog2(NREQ);
  localparam logic [CW-1:0]   CNT_MAX = '1;
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [NREQ-1:0] REQ_ONE = NREQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   tmr_q, tmr_d;
  logic [LW-1:0]   last_q, last_d;
  logic [LW-1:0]   win_q, win_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            sat_q, sat_d;
  logic [LW-1:0]   pick;

  // First asserted request strictly after 'last', wrapping to index 0.
  function automatic logic [LW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [LW-1:0]   last);
    logic [LW-1:0] sel;
    logic [LW-1:0] idx_l;
    logic          found;
    int            idx;
    sel   = last;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(last) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_l = LW'(idx);
      if (!found && r[idx_l]) begin
        found = 1'b1;
        sel   = idx_l;
      end
    end
    return sel;
  endfunction

  assign pick = rr_pick(req, last_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (!clr && |req)          state_d = S_MEASURE;
      S_MEASURE: if (clr)                   state_d = S_IDLE;
                 else if (!req[win_q])      state_d = S_WAIT;
      S_WAIT:    if (clr)                   state_d = S_IDLE;
                 else if (tmr_q == CNT_ONE) state_d = S_DONE;
      S_DONE:                               state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    last_d  = last_q;
    win_d   = win_q;
    grant_d = grant_q;
    done_d  = '0;
    sat_d   = sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (!clr && |req) begin
          win_d   = pick;
          cnt_d   = CNT_ONE;
          grant_d = REQ_ONE << pick;
          sat_d   = 1'b0;
        end
      end
      S_MEASURE: begin
        if (clr) begin
          grant_d = '0;
          sat_d   = 1'b0;
        end else if (req[win_q]) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_MAX - CNT_ONE) sat_d = 1'b1;
          end
        end else begin
          tmr_d = cnt_q;
        end
      end
      S_WAIT: begin
        if (clr) begin
          grant_d = '0;
          sat_d   = 1'b0;
        end else if (tmr_q == CNT_ONE) begin
          done_d = grant_q;
        end else begin
          tmr_d = tmr_q - CNT_ONE;
        end
      end
      S_DONE: begin
        if (!clr) last_d = win_q;
        grant_d = '0;
        sat_d   = 1'b0;
      end
      default: begin
        grant_d = '0;
        sat_d   = 1'b0;
      end
    endcase
  end

  // last resets to the top index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      tmr_q   <= '0;
      last_q  <= LW'(NREQ - 1);
      win_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      last_q  <= last_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign sat   = sat_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_echo_delay_sched.sv
// Scenario bench for echo_delay_sched: expected done pulses (owner, cycle) are
// queued when a requester releases, and a negedge monitor retires them.
module tb_echo_delay_sched;

  localparam int NREQ    = 4;
  localparam int CW      = 4;
  localparam int SAT_MAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic            clr;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] done;
  logic            busy;
  logic            sat;

  echo_delay_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .clr   (clr),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .sat   (sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Retire expected done pulses; any unexpected or late pulse is an error.
  always @(negedge clk) begin
    if (done !== '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: done=%b at cycle %0d, none expected", done, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (done !== (4'b0001 << mon_e.idx) || cyc != mon_e.at) begin
          errors++;
          $display("FAIL done_pulse: done=%b at cycle %0d, expected owner %0d at cycle %0d",
                   done, cyc, mon_e.idx, mon_e.at);
        end
      end
    end else if (sb.size() > 0 && cyc > sb[0].at) begin
      checks++;
      errors++;
      $display("FAIL done_missing: no done by cycle %0d, expected owner %0d at cycle %0d",
               cyc, sb[0].idx, sb[0].at);
      void'(sb.pop_front());
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    clr   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input logic [NREQ-1:0] exp_g, input string tag);
    bit ok = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (grant !== '0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || grant !== exp_g || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_grant: grant=%b busy=%b, expected grant=%b busy=1", tag, grant, busy, exp_g);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || grant !== '0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b grant=%b sat=%b, expected 0/0000/0", tag, busy, grant, sat);
    end
  endtask

  // Raise req[idx], hold it for n sampling edges counted from selection, release.
  task automatic pulse(input int idx, input int n, input string tag);
    int c;
    logic [NREQ-1:0] exp_g;
    exp_g = 4'b0001 << idx;
    @(negedge clk);
    req[idx] = 1'b1;
    wait_grant(exp_g, tag);
    for (int j = 1; j <= n; j++) begin
      if (j > 1) @(negedge clk);
      checks++;
      if (grant !== exp_g || busy !== 1'b1 || sat !== (j >= SAT_MAX)) begin
        errors++;
        $display("FAIL %s_measure: edge %0d grant=%b busy=%b sat=%b, expected grant=%b busy=1 sat=%0d",
                 tag, j, grant, busy, sat, exp_g, (j >= SAT_MAX));
      end
    end
    req[idx] = 1'b0;
    c = (n < SAT_MAX) ? n : SAT_MAX;
    sb.push_back('{idx: idx, at: cyc + 1 + c});
    wait_idle(tag);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (grant !== '0 || done !== '0 || busy !== 1'b0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: grant=%b done=%b busy=%b sat=%b, expected all zero", grant, done, busy, sat);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (grant !== '0 || done !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: grant=%b done=%b busy=%b, expected all zero", grant, done, busy);
    end
  endtask

  task automatic test_single();
    pulse(1, 3, "single");
  endtask

  task automatic test_min_width();
    pulse(0, 1, "min_width");
  endtask

  task automatic test_saturation();
    pulse(2, 20, "saturation");
  endtask

  task automatic test_contention();
    int e;
    do_reset();
    @(negedge clk);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e = k % NREQ;
      wait_grant(4'b0001 << e, "contention");
      @(negedge clk);
      req[e] = 1'b0;
      sb.push_back('{idx: e, at: cyc + 1 + 2});
      wait_idle("contention");
      if (k < 4) req[e] = 1'b1;
      else       req = '0;
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    req = 4'b0010;
    wait_grant(4'b0010, "abort_first");
    repeat (3) @(negedge clk);
    req = '0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (busy !== 1'b0 || grant !== '0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b grant=%b sat=%b, expected 0/0000/0", busy, grant, sat);
    end
    req = 4'b0011;
    wait_grant(4'b0010, "abort_last_kept");
    req = '0;
    sb.push_back('{idx: 1, at: cyc + 1 + 1});
    wait_idle("abort_last_kept");
    req = 4'b0100;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL clr_in_idle: busy=%b grant=%b, expected selection suppressed", busy, grant);
    end
    wait_grant(4'b0100, "clr_in_idle");
    req = '0;
    sb.push_back('{idx: 2, at: cyc + 1 + 1});
    wait_idle("clr_in_idle");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req = 4'b1000;
    wait_grant(4'b1000, "async_pre");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || done !== '0 || busy !== 1'b0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: grant=%b done=%b busy=%b sat=%b, expected all zero", grant, done, busy, sat);
    end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0101;
    wait_grant(4'b0001, "async_post");
    req = '0;
    sb.push_back('{idx: 0, at: cyc + 1 + 1});
    wait_idle("async_post");
  endtask

  initial begin
    test_reset();
    test_single();
    test_min_width();
    test_saturation();
    test_contention();
    test_abort();
    test_async_reset();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d done pulses outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/echo_delay_sched.md
ECHO_DELAY_SCHED -- requirements
Module: echo_delay_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the single measure/delay timer; range 2..8.
REQ-002 Parameter CW, default 4: width of the shared timer counter.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port req  input  NREQ  level request per requester; held high for the pulse width to be echoed.
REQ-006 Port clr  input  1  synchronous abort of the current transaction.
REQ-007 Port grant  output  NREQ  one-hot owner of the timer; all-zero when idle.
REQ-008 Port done  output  NREQ  one-cycle echo pulse to the owning requester.
REQ-009 Port busy  output  1  high whenever state is not IDLE.
REQ-010 Port sat  output  1  high from the edge the count saturates until that transaction returns to IDLE.

Function
REQ-011 The block SHALL implement FSM states IDLE, MEASURE, WAIT, DONE.
REQ-012 IDLE: on an edge sampling req != 0, SHALL select winner w round-robin, searching from index last+1 upward with wrap to 0; load cnt=1; grant=onehot(w); go to MEASURE.
REQ-013 IDLE with req == 0: SHALL stay in IDLE; grant and done zero.
REQ-014 MEASURE, edge sampling req[w]=1: cnt SHALL increment, saturating at 2^CW-1; sat set on reaching saturation.
REQ-015 MEASURE, edge sampling req[w]=0: SHALL load tmr=cnt and go to WAIT.
REQ-016 WAIT, each edge: if tmr==1, go to DONE; else decrement tmr.
REQ-017 Net effect: done[w] SHALL be high exactly cnt clock cycles after the edge that first samples req[w] low, where cnt is the number of edges at which req[w] was sampled high, counting from the IDLE selection edge.
REQ-018 DONE: done[w]=1 for exactly one cycle; at the next edge SHALL update last=w, clear grant, clear sat, and return to IDLE.
REQ-019 Back-to-back: a request pending at the DONE->IDLE edge SHALL be granted no earlier than the following edge (one IDLE cycle minimum between transactions).
REQ-020 Requests other than req[w] SHALL be ignored while busy; losers are not queued and must hold req high until granted.
REQ-021 Width measurement SHALL start at the selection edge; time a requester spends waiting for grant is not counted.
REQ-022 req[w] toggling during WAIT or DONE SHALL be ignored.
REQ-023 clr sampled high in any non-IDLE state SHALL return to IDLE at that edge, clear grant and sat, leave last unchanged, and produce no done; clr in IDLE has no effect, and selection is suppressed on that edge.
REQ-024 done and grant SHALL be registered outputs, glitch-free and at most one-hot.
REQ-025 tmr and cnt SHALL never take the value 0 in WAIT.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, grant=0, done=0, busy=0, sat=0, cnt=0, tmr=0, last=NREQ-1, so that req[0] has top priority after reset.
REQ-027 Reset asserted mid-transaction SHALL abort it with no done pulse; after release, operation resumes from IDLE on the first edge.

Verification
REQ-028 Single request: req[1] high across 3 edges from selection, then low -> grant=0010 for the whole transaction; done[1] high exactly 3 cycles after the low-sample edge, for 1 cycle.
REQ-029 Contention: req=1111 held after reset -> grants in order 0,1,2,3,0; each done goes only to its owner; at least one IDLE cycle between grants.
REQ-030 Saturation (CW=4): req[2] held 20 edges -> cnt stops at 15 and sat rises at that edge; done[2] comes 15 cycles after the low-sample edge; sat clears on return to IDLE.
REQ-031 Minimum width: req[0] high for 1 edge only -> cnt=1; done[0] comes 1 cycle after the low-sample edge.
REQ-032 Abort: clr pulsed during WAIT -> idle on the next edge, no done; the next request is arbitrated from the unchanged last.
REQ-033 Async reset during MEASURE between clock edges -> outputs zero immediately without a clock; after release, req=0101 grants index 0 first.
